// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types.
// FSM state encoding and well-known scan-code prefixes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for PS/2 clock and data,
// plus a one-cycle pulse on the synchronized clock falling edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic fall
);

  logic [1:0] c_ff;
  logic [1:0] d_ff;
  logic       c_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      c_ff <= 2'b11;
      d_ff <= 2'b11;
      c_q  <= 1'b1;
    end else begin
      c_ff <= {c_ff[0], ps2_clk};
      d_ff <= {d_ff[0], ps2_dat};
      c_q  <= c_ff[1];
    end
  end

  assign dat_s = d_ff[1];
  assign fall  = c_q & ~c_ff[1];

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard frame receiver feeding a 16-bit
// scan-code window for a 4-digit hex display.
module ps2_kbd
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PS2_KBCLK,
  input  logic        PS2_KBDAT,
  output logic [15:0] hex
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  ps2_state_t  state;
  logic        dat_s;
  logic        fall;
  logic [2:0]  cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]  data_reg;
  logic        parity_reg;
  logic [7:0]  code_reg;
  logic [7:0]  prev_reg;

  ps2_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (PS2_KBCLK),
    .ps2_dat (PS2_KBDAT),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      to_cnt     <= '0;
      data_reg   <= '0;
      parity_reg <= 1'b0;
      code_reg   <= '0;
      prev_reg   <= '0;
    end else if (state != IDLE && !fall
                 && to_cnt == TO_MAX) begin
      // Keyboard stalled mid-frame: drop it.
      state  <= IDLE;
      to_cnt <= '0;
      cnt    <= '0;
    end else begin
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!dat_s) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            data_reg[cnt] <= dat_s;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_reg <= dat_s;
            state      <= STOP;
          end
          STOP: begin
            if (dat_s && ^{data_reg, parity_reg}) begin
              code_reg <= data_reg;
              prev_reg <= code_reg;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign hex = {prev_reg, code_reg};

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: framing, parity,
// stop bit, timeout and reset behaviour.
module tb_ps2_kbd;
  import ps2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        kbclk = 1'b1;
  logic        kbdat = 1'b1;
  logic [15:0] hex;

  int checks = 0;
  int errors = 0;

  ps2_kbd #(.TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PS2_KBCLK (kbclk),
    .PS2_KBDAT (kbdat),
    .hex       (hex)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    kbclk = 1'b1;
    kbdat = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
  endtask

  task automatic send_bit(input logic b);
    cyc(1);
    kbdat = b;
    cyc(4);
    kbclk = 1'b0;
    cyc(5);
    kbclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic bad_par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ bad_par);
    send_bit(stop);
    cyc(6);
    kbdat = 1'b1;
    cyc(2);
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  logic [7:0]  seq_b [6];
  logic [15:0] seq_h [6];

  initial begin
    seq_b = '{PS2_EXT, PS2_BRK, 8'h11,
              8'hFF, 8'hFF, 8'hFF};
    seq_h = '{16'h00E0, 16'hE0F0, 16'hF011,
              16'h11FF, 16'hFFFF, 16'hFFFF};

    do_reset();
    chk("rst_hex", hex, 16'h0000);
    chk("rst_state", 16'(dut.state), 16'(IDLE));
    cyc(30);
    chk("idle_hex", hex, 16'h0000);

    good(PS2_EXT);
    chk("e0", hex, 16'h00E0);
    good(8'h11);
    chk("e011", hex, 16'hE011);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      good(seq_b[i]);
      chk($sformatf("seq%0d", i), hex, seq_h[i]);
    end

    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("badpar_hex", hex, 16'h0000);
    chk("badpar_st", 16'(dut.state), 16'(IDLE));
    good(8'h1C);
    chk("good1c", hex, 16'h001C);

    send_frame(8'h5A, 1'b0, 1'b0);
    chk("badstop_hex", hex, 16'h001C);
    chk("badstop_st", 16'(dut.state), 16'(IDLE));
    good(8'h5A);
    chk("good5a", hex, 16'h1C5A);

    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(70);
    chk("to_state", 16'(dut.state), 16'(IDLE));
    good(8'h29);
    chk("to_29", hex, 16'h0029);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    cyc(2);
    rst_n = 1'b1;
    kbclk = 1'b1;
    kbdat = 1'b1;
    cyc(3);
    chk("midrst_hex", hex, 16'h0000);
    chk("midrst_st", 16'(dut.state), 16'(IDLE));
    rst_n = 1'b0;
    cyc(3);
    good(8'h1C);
    chk("post_rst", hex, 16'h001C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
